v_shift_cmd_queue: RTL and testbench

Buffered command stage sitting directly upstream of the 8-bit logical shifter (DI/SEL -> SO). It accepts shift commands (data byte plus 2-bit shift select) over a valid/ready handshake, queues them in a small first-word-fall-through FIFO, and presents one command at a time on registered DI/SEL outputs. Select codes are canonicalised on entry so the shifter only ever sees 2'b00, 2'b01 or 2'b10.

---
 rtl/v_shift_cmd_queue.sv | 110 +++++++++++
 tb/tb_v_shift_cmd_queue.sv | 189 ++++++++++++++++++
 2 files changed

// File: rtl/v_shift_cmd_queue.sv
// Command queue in front of the 8-bit logical shifter: a small FWFT FIFO with a registered
// DI/SEL head. SEL 2'b11 is folded to 2'b10 on entry so the shifter never sees it.
module v_shift_cmd_queue #(
  parameter int unsigned  DEPTH = 4,
  localparam int unsigned AW    = $clog2(DEPTH)
) (
  input  logic        CLK,
  input  logic        CLR_N,
  input  logic [7:0]  DI_IN,
  input  logic [1:0]  SEL_IN,
  input  logic        IN_VALID,
  output logic        IN_READY,
  output logic [7:0]  DI,
  output logic [1:0]  SEL,
  output logic        OUT_VALID,
  input  logic        OUT_READY,
  output logic [AW:0] LEVEL
);

  if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : gen_depth_check
    $error("DEPTH must be a power of two and at least 2");
  end

  typedef struct packed {
    logic [7:0] data;
    logic [1:0] sel;
  } cmd_t;

  localparam logic [AW:0] FullLevel = (AW+1)'(DEPTH);
  localparam logic [AW:0] OneLevel  = (AW+1)'(1);

  cmd_t          mem_q [DEPTH];
  logic [AW-1:0] wptr_q, rptr_q, rptr_nxt;
  logic [AW:0]   level_q, level_d;
  logic          out_valid_q, out_valid_d;
  cmd_t          out_q, out_d;
  cmd_t          in_cmd;
  logic          push, pop;

  assign in_cmd.data = DI_IN;
  assign in_cmd.sel  = (SEL_IN == 2'b11) ? 2'b10 : SEL_IN;

  // Ready depends only on the registered level, never on OUT_READY.
  assign IN_READY = (level_q != FullLevel);
  assign push     = IN_VALID && IN_READY;
  assign pop      = out_valid_q && OUT_READY;
  assign rptr_nxt = rptr_q + AW'(1);

  always_comb begin
    level_d = level_q;
    case ({push, pop})
      2'b10:   level_d = level_q + OneLevel;
      2'b01:   level_d = level_q - OneLevel;
      default: level_d = level_q;
    endcase
  end

  // The output register mirrors mem_q[rptr_q] whenever OUT_VALID is set.
  always_comb begin
    out_d       = out_q;
    out_valid_d = out_valid_q;
    if (pop) begin
      if (level_q > OneLevel) begin
        out_d       = mem_q[rptr_nxt];
        out_valid_d = 1'b1;
      end else if (push) begin
        // Last entry leaves while a new one arrives: forward it so OUT_VALID never drops.
        out_d       = in_cmd;
        out_valid_d = 1'b1;
      end else begin
        out_valid_d = 1'b0;
      end
    end else if (!out_valid_q && level_q != '0) begin
      out_d       = mem_q[rptr_q];
      out_valid_d = 1'b1;
    end
  end

  always_ff @(posedge CLK or negedge CLR_N) begin
    if (!CLR_N) begin
      wptr_q      <= '0;
      rptr_q      <= '0;
      level_q     <= '0;
      out_valid_q <= 1'b0;
      out_q       <= '0;
    end else begin
      if (push) begin
        wptr_q <= wptr_q + AW'(1);
      end
      if (pop) begin
        rptr_q <= rptr_nxt;
      end
      level_q     <= level_d;
      out_valid_q <= out_valid_d;
      out_q       <= out_d;
    end
  end

  always_ff @(posedge CLK) begin
    if (push) begin
      mem_q[wptr_q] <= in_cmd;
    end
  end

  assign DI        = out_q.data;
  assign SEL       = out_q.sel;
  assign OUT_VALID = out_valid_q;
  assign LEVEL     = level_q;

endmodule

// File: tb/tb_v_shift_cmd_queue.sv
// Scoreboard bench for v_shift_cmd_queue: stimulus queues expected commands, a monitor
// process checks level, ready, head contents, ordering and latency every cycle.
module tb_v_shift_cmd_queue;
  localparam int unsigned DEPTH = 4;

  logic       CLK = 1'b0;
  logic       CLR_N;
  logic [7:0] DI_IN;
  logic [1:0] SEL_IN;
  logic       IN_VALID;
  logic       IN_READY;
  logic [7:0] DI;
  logic [1:0] SEL;
  logic       OUT_VALID;
  logic       OUT_READY;
  logic [2:0] LEVEL;

  v_shift_cmd_queue #(.DEPTH(DEPTH)) dut (
    .CLK       (CLK),
    .CLR_N     (CLR_N),
    .DI_IN     (DI_IN),
    .SEL_IN    (SEL_IN),
    .IN_VALID  (IN_VALID),
    .IN_READY  (IN_READY),
    .DI        (DI),
    .SEL       (SEL),
    .OUT_VALID (OUT_VALID),
    .OUT_READY (OUT_READY),
    .LEVEL     (LEVEL)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    logic [7:0] data;
    logic [1:0] sel;
    int         cyc;
  } exp_t;

  exp_t exp_q[$];
  int   n_cmp = 0;
  int   n_bad = 0;
  int   cyc = 0;
  int   mdl_level = 0;
  bit   push_flag = 1'b0;
  bit   chk_lat = 1'b0;

  always @(posedge CLK) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, req, $time);
    end
  endtask

  function automatic logic [1:0] canon(input logic [1:0] s);
    return (s == 2'b11) ? 2'b10 : s;
  endfunction

  // One cycle of stimulus; the expected command is queued if the model says it is accepted.
  task automatic step(input bit iv, input logic [7:0] d, input logic [1:0] s, input bit ordy);
    @(negedge CLK);
    IN_VALID  = iv;
    DI_IN     = d;
    SEL_IN    = s;
    OUT_READY = ordy;
    #2;
    push_flag = iv && (mdl_level != DEPTH);
    if (push_flag) exp_q.push_back('{d, canon(s), cyc});
  endtask

  task automatic drain();
    for (int i = 0; i < 20 && exp_q.size() != 0; i++) step(1'b0, 8'h00, 2'b00, 1'b1);
    check("drain_empty", 32'(exp_q.size()), 32'd0);
  endtask

  initial begin : monitor
    exp_t head;
    bit   pop;
    forever begin
      @(negedge CLK);
      #3;
      if (CLR_N) begin
        check("level", 32'(LEVEL), 32'(mdl_level));
        check("in_ready", 32'(IN_READY), 32'(mdl_level != DEPTH));
        // A queued command must be on the output within two edges of its push.
        if (exp_q.size() != 0 && exp_q[0].cyc + 2 <= cyc) check("out_valid", 32'(OUT_VALID), 32'd1);
        pop = OUT_VALID && OUT_READY;
        if (OUT_VALID) begin
          if (exp_q.size() == 0) begin
            check("spurious_valid", 32'(OUT_VALID), 32'd0);
          end else begin
            head = exp_q[0];
            check("di", 32'(DI), 32'(head.data));
            check("sel", 32'(SEL), 32'(head.sel));
            if (pop) begin
              void'(exp_q.pop_front());
              if (chk_lat) check("latency", 32'(cyc - head.cyc), 32'd2);
            end
          end
        end
        mdl_level = mdl_level + int'(push_flag) - int'(pop);
      end
      push_flag = 1'b0;
    end
  end

  initial begin : stim
    CLR_N     = 1'b1;
    IN_VALID  = 1'b0;
    OUT_READY = 1'b0;
    DI_IN     = 8'h00;
    SEL_IN    = 2'b00;
    #1 CLR_N = 1'b0;
    #1;
    check("rst_out_valid", 32'(OUT_VALID), 32'd0);
    check("rst_level", 32'(LEVEL), 32'd0);
    check("rst_in_ready", 32'(IN_READY), 32'd1);
    @(posedge CLK);
    @(posedge CLK);
    #2 CLR_N = 1'b1;

    // Canonicalisation and ordering, back-to-back into an empty queue.
    chk_lat = 1'b1;
    step(1'b1, 8'h11, 2'b00, 1'b1);
    step(1'b1, 8'h22, 2'b01, 1'b1);
    step(1'b1, 8'h33, 2'b10, 1'b1);
    step(1'b1, 8'h44, 2'b11, 1'b1);
    drain();
    chk_lat = 1'b0;

    // Fill with backpressure: only 01..04 fit.
    for (int i = 1; i <= 6; i++) step(1'b1, 8'(i), 2'b00, 1'b0);
    step(1'b1, 8'h07, 2'b00, 1'b1);
    check("full_level", 32'(LEVEL), 32'd4);
    check("full_in_ready", 32'(IN_READY), 32'd0);
    check("full_di", 32'(DI), 32'h01);
    step(1'b0, 8'h00, 2'b00, 1'b0);
    check("after_pop_level", 32'(LEVEL), 32'd3);
    check("after_pop_in_ready", 32'(IN_READY), 32'd1);
    drain();

    // Streaming across several pointer wraps.
    chk_lat = 1'b1;
    for (int i = 0; i < 20; i++) step(1'b1, 8'(i), 2'(i), 1'b1);
    drain();
    chk_lat = 1'b0;

    // Asynchronous reset mid-stream with three commands held.
    step(1'b1, 8'hB1, 2'b00, 1'b0);
    step(1'b1, 8'hB2, 2'b01, 1'b0);
    step(1'b1, 8'hB3, 2'b10, 1'b0);
    step(1'b0, 8'h00, 2'b00, 1'b0);
    check("pre_rst_level", 32'(LEVEL), 32'd3);
    #1 CLR_N = 1'b0;
    #1;
    check("mid_rst_out_valid", 32'(OUT_VALID), 32'd0);
    check("mid_rst_di", 32'(DI), 32'h00);
    check("mid_rst_sel", 32'(SEL), 32'd0);
    check("mid_rst_level", 32'(LEVEL), 32'd0);
    check("mid_rst_in_ready", 32'(IN_READY), 32'd1);
    exp_q.delete();
    mdl_level = 0;
    push_flag = 1'b0;
    @(posedge CLK);
    #2 CLR_N = 1'b1;
    step(1'b1, 8'hA5, 2'b01, 1'b0);
    step(1'b0, 8'h00, 2'b00, 1'b0);
    check("no_bypass_valid", 32'(OUT_VALID), 32'd0);
    step(1'b0, 8'h00, 2'b00, 1'b0);
    check("a5_valid", 32'(OUT_VALID), 32'd1);
    check("a5_di", 32'(DI), 32'hA5);
    check("a5_sel", 32'(SEL), 32'd1);
    drain();

    // Random stalls on both sides.
    for (int i = 0; i < 1000; i++) begin
      step(1'($urandom_range(0, 1)), 8'($urandom), 2'($urandom), 1'($urandom_range(0, 1)));
    end
    drain();
    step(1'b0, 8'h00, 2'b00, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
